// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Holds the FSM state enum, the PC step and the branch-target alignment mask.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam int unsigned PC_INC = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b00;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid buffer for a fetched instruction and its pc+4.
// Ports: clk, rst (async active-low), capture, invalidate, d_instr/d_pc4 in, q_instr/q_pc4/valid out.
module fetch_hold_buf #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         capture,
  input  logic         invalidate,
  input  logic [N-1:0] d_instr,
  input  logic [N-1:0] d_pc4,
  output logic [N-1:0] q_instr,
  output logic [N-1:0] q_pc4,
  output logic         valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid   <= 1'b0;
      q_instr <= '0;
      q_pc4   <= '0;
    end else if (invalidate) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid   <= 1'b1;
      q_instr <= d_instr;
      q_pc4   <= d_pc4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, handshakes with imem, feeds IF/ID (ld/clr/in1/in2).
// Ports: clk, rst (async active-low), stall, branch_*, imem_*, pc_plus4, instr, ifid_ld, ifid_clr.
// Optional FETCH_STATS_EN adds fetch_count and flush_count outputs.
import fetch_pkg::*;

module fetch_unit #(
  parameter int          N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_addr,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic [N-1:0] imem_rdata,
  output logic [N-1:0] pc_plus4,
  output logic [N-1:0] instr,
`ifdef FETCH_STATS_EN
  output logic [31:0]  fetch_count,
  output logic [31:0]  flush_count,
`endif
  output logic         ifid_ld,
  output logic         ifid_clr
);

  state_t       state, state_n;
  logic [N-1:0] pc, pc_n, pc4;
  logic [N-1:0] drop_addr, drop_addr_n;
  logic [N-1:0] last_pc4, last_instr;
  logic [N-1:0] hb_instr, hb_pc4;
  logic         hb_valid, hb_cap, hb_inv;
  logic         resp;

  assign pc4       = pc + N'(PC_INC);
  assign imem_req  = rst && (state != HOLD);
  assign resp      = imem_req && imem_ready;
  // DROP keeps the abandoned address on the bus until memory answers.
  assign imem_addr = (state == DROP) ? drop_addr : pc;

  fetch_hold_buf #(.N(N)) u_hb (
    .clk        (clk),
    .rst        (rst),
    .capture    (hb_cap),
    .invalidate (hb_inv),
    .d_instr    (imem_rdata),
    .d_pc4      (pc4),
    .q_instr    (hb_instr),
    .q_pc4      (hb_pc4),
    .valid      (hb_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drop_addr  <= '0;
      last_pc4   <= '0;
      last_instr <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      drop_addr <= drop_addr_n;
      if (ifid_ld) begin
        last_pc4   <= pc_plus4;
        last_instr <= instr;
      end
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    drop_addr_n = drop_addr;
    ifid_ld     = 1'b0;
    ifid_clr    = 1'b0;
    hb_cap      = 1'b0;
    hb_inv      = 1'b0;
    pc_plus4    = last_pc4;
    instr       = last_instr;
    if (state == HOLD) begin
      pc_plus4 = hb_pc4;
      instr    = hb_instr;
    end
    if (rst && branch_taken) begin
      ifid_clr = 1'b1;
      hb_inv   = 1'b1;
      pc_n     = {branch_addr[N-1:2], branch_addr[1:0] & ALIGN_MASK};
      if (imem_req && !imem_ready) begin
        state_n = DROP;
        if (state != DROP) drop_addr_n = pc;
      end else begin
        state_n = FETCH;
      end
    end else if (rst) begin
      unique case (state)
        FETCH: begin
          if (resp) begin
            pc_n = pc4;
            if (stall) begin
              hb_cap  = 1'b1;
              state_n = HOLD;
            end else begin
              ifid_ld  = 1'b1;
              pc_plus4 = pc4;
              instr    = imem_rdata;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_ld = hb_valid;
            state_n = FETCH;
          end
        end
        DROP: begin
          if (imem_ready) state_n = FETCH;
        end
        default: state_n = FETCH;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (ifid_ld)  fetch_count <= fetch_count + 32'd1;
      if (ifid_clr) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transaction-level reference model.
// A second instance checks RESET_PC wrap-around.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch_taken, imem_ready;
  logic [31:0] branch_addr;
  logic        imem_req, ifid_ld, ifid_clr;
  logic [31:0] imem_addr, imem_rdata, pc_plus4, instr;
  logic        w_req, w_ld, w_clr;
  logic [31:0] w_addr, w_rdata, w_pc4, w_instr;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, flush_count, w_fc, w_flc;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'd8) return 32'hE3A0_1005;
    return a * 3 + 32'h1300_0013;
  endfunction

  assign imem_rdata = mem(imem_addr);
  assign w_rdata    = mem(w_addr);

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pc_plus4(pc_plus4), .instr(instr),
`ifdef FETCH_STATS_EN
    .fetch_count(fetch_count), .flush_count(flush_count),
`endif
    .ifid_ld(ifid_ld), .ifid_clr(ifid_clr)
  );

  fetch_unit #(.N(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .stall(1'b0),
    .branch_taken(1'b0), .branch_addr(32'd0),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_rdata(w_rdata),
    .pc_plus4(w_pc4), .instr(w_instr),
`ifdef FETCH_STATS_EN
    .fetch_count(w_fc), .flush_count(w_flc),
`endif
    .ifid_ld(w_ld), .ifid_clr(w_clr)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] p4;
  } ent_t;

  logic [31:0] m_pc = 32'd0;
  logic        m_drop = 1'b0;
  logic [31:0] m_drop_addr = 32'd0;
  ent_t        m_buf[$];
  int          m_fetch = 0;
  int          m_flush = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0;
    m_drop = 1'b0;
    m_buf.delete();
    m_fetch = 0;
    m_flush = 0;
  endtask

  task automatic model_check();
    logic        e_req, e_ld, e_clr, show;
    logic [31:0] e_addr, e_p4, e_in;
    e_req  = (m_buf.size() == 0);
    e_addr = m_drop ? m_drop_addr : m_pc;
    e_ld   = 1'b0;
    e_clr  = 1'b0;
    show   = 1'b0;
    e_p4   = 32'd0;
    e_in   = 32'd0;
    if (m_buf.size() != 0) begin
      e_p4 = m_buf[0].p4;
      e_in = m_buf[0].ins;
      show = 1'b1;
    end
`ifdef FETCH_STATS_EN
    chk("m_fetch_count", fetch_count, 32'(m_fetch));
    chk("m_flush_count", flush_count, 32'(m_flush));
`endif
    if (branch_taken) begin
      e_clr = 1'b1;
      if (e_req && !imem_ready) begin
        if (!m_drop) m_drop_addr = m_pc;
        m_drop = 1'b1;
      end else begin
        m_drop = 1'b0;
      end
      m_pc = branch_addr & ~32'd3;
      m_buf.delete();
    end else if (m_drop) begin
      if (imem_ready) m_drop = 1'b0;
    end else if (m_buf.size() != 0) begin
      if (!stall) begin
        e_ld = 1'b1;
        m_buf.delete();
      end
    end else if (imem_ready) begin
      if (stall) begin
        m_buf.push_back('{ins: mem(m_pc), p4: m_pc + 32'd4});
      end else begin
        e_ld = 1'b1;
        e_p4 = m_pc + 32'd4;
        e_in = mem(m_pc);
        show = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end
    chk("m_req", {31'd0, imem_req}, {31'd0, e_req});
    if (e_req) chk("m_addr", imem_addr, e_addr);
    chk("m_ld", {31'd0, ifid_ld}, {31'd0, e_ld});
    chk("m_clr", {31'd0, ifid_clr}, {31'd0, e_clr});
    if (show) begin
      chk("m_pc4", pc_plus4, e_p4);
      chk("m_instr", instr, e_in);
    end
    if (e_ld) m_fetch++;
    if (e_clr) m_flush++;
  endtask

  task automatic cyc(input logic rdy, input logic stl,
                     input logic br, input logic [31:0] ba);
    imem_ready   = rdy;
    stall        = stl;
    branch_taken = br;
    branch_addr  = ba;
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_addr = 32'd0;
    imem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_ld", {31'd0, ifid_ld}, 32'd0);
    chk("rst_clr", {31'd0, ifid_clr}, 32'd0);
    chk("rst_pc4", pc_plus4, 32'd0);
    chk("rst_instr", instr, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'd0);
      chk("t1_addr", imem_addr, 32'(i * 4));
      chk("t1_ld", {31'd0, ifid_ld}, 32'd1);
      chk("t1_pc4", pc_plus4, 32'(i * 4 + 4));
      if (i == 0) begin
        chk("wrap_addr", w_addr, 32'hFFFF_FFFC);
        chk("wrap_pc4", w_pc4, 32'd0);
      end
      if (i == 1) chk("wrap_next_addr", w_addr, 32'd0);
      adv();
    end

    cyc(1'b1, 1'b0, 1'b1, 32'd8);
    chk("t2_br_clr", {31'd0, ifid_clr}, 32'd1);
    adv();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'd0);
      chk("t2_stall_ld", {31'd0, ifid_ld}, 32'd0);
      if (i > 0) chk("t2_hold_req", {31'd0, imem_req}, 32'd0);
      adv();
    end
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    chk("t2_ld", {31'd0, ifid_ld}, 32'd1);
    chk("t2_instr", instr, 32'hE3A0_1005);
    chk("t2_pc4", pc_plus4, 32'd12);
    adv();
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    chk("t2_next_addr", imem_addr, 32'd12);
    adv();

    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    adv();
    cyc(1'b0, 1'b0, 1'b1, 32'h103);
    chk("t3_clr", {31'd0, ifid_clr}, 32'd1);
    adv();
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("t3_drop_addr", imem_addr, 32'd16);
    adv();
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    chk("t3_discard_ld", {31'd0, ifid_ld}, 32'd0);
    adv();
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    chk("t3_tgt_addr", imem_addr, 32'h100);
    chk("t3_tgt_pc4", pc_plus4, 32'h104);
    adv();

    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    adv();
    cyc(1'b0, 1'b1, 1'b1, 32'h200);
    chk("t4_clr", {31'd0, ifid_clr}, 32'd1);
    adv();
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    chk("t4_addr", imem_addr, 32'h200);
    chk("t4_pc4", pc_plus4, 32'h204);
    adv();

    cyc(1'b0, 1'b0, 1'b1, 32'h300);
    adv();
    cyc(1'b0, 1'b0, 1'b1, 32'h401);
    adv();
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    adv();
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    chk("t5_addr", imem_addr, 32'h400);
    adv();
    cyc(1'b1, 1'b1, 1'b1, 32'h500);
    adv();
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    adv();

    imem_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("t6_req", {31'd0, imem_req}, 32'd0);
    chk("t6_ld", {31'd0, ifid_ld}, 32'd0);
    chk("t6_pc4", pc_plus4, 32'd0);
    chk("t6_instr", instr, 32'd0);
`ifdef FETCH_STATS_EN
    chk("t6_fetch_count", fetch_count, 32'd0);
    chk("t6_flush_count", flush_count, 32'd0);
`endif
    model_reset();
    #1;
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("t6_addr", imem_addr, 32'd0);
    adv();
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    chk("t6_pc4_after", pc_plus4, 32'd4);
    adv();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
